// File: rtl/scan_mux_pkg.sv
// Shared definitions for scan_mux_pipe and its stage-1 mux cell.
//   clog2       : ceiling log2, used to size the channel select
//   mode_e      : encoding of the mode input (manual / auto-scan)
//   state_e     : scan sequencer states
//   params_ok   : legal range check for N and DWELL
package scan_mux_pkg;

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;
  typedef enum logic {ST_MANUAL   = 1'b0, ST_SCAN   = 1'b1} state_e;

  localparam int N_MIN     = 4;
  localparam int N_MAX     = 64;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 255;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int n, input int dwell);
    return (n % 4 == 0) && (n >= N_MIN) && (n <= N_MAX) &&
           (dwell >= DWELL_MIN) && (dwell <= DWELL_MAX);
  endfunction

endpackage

// File: rtl/scan_mux_pipe_mux4_reg.sv
// mux4_reg: registered W-bit 4:1 mux (stage 1 of scan_mux_pipe).
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the output register
//   d_i   : four W-bit candidates
//   sel_i : 2-bit select
//   q_o   : registered selected value
module mux4_reg #(
  parameter int W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0][W-1:0] d_i,
  input  logic [1:0]        sel_i,
  output logic [W-1:0]      q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= d_i[sel_i];
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_mux_pipe.sv
// scan_mux_pipe: two-stage pipelined N-channel W-bit mux with manual select
// and an optional auto-scan sequencer (macro SCAN_MUX_AUTOSCAN_EN).
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : N packed channels, channel k at [k*W +: W]
//   in_valid   : in_data qualifier
//   sel        : manual select / scan start channel
//   mode       : 0 manual, 1 auto-scan (ignored when the macro is undefined)
//   out_data   : selected channel, 2 cycles after sampling
//   out_sel    : channel index that produced out_data
//   out_valid  : out_data qualifier
//   scan_wrap  : one-cycle pulse after the scan index wraps N-1 -> 0
module scan_mux_pipe
  import scan_mux_pkg::*;
#(
  parameter int W     = 3,
  parameter int N     = 8,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*W-1:0]      in_data,
  input  logic                in_valid,
  input  logic [clog2(N)-1:0] sel,
  input  logic                mode,
  output logic [W-1:0]        out_data,
  output logic [clog2(N)-1:0] out_sel,
  output logic                out_valid,
  output logic                scan_wrap
);

  localparam int S = clog2(N);
  localparam int G = N / 4;

  if (!params_ok(N, DWELL)) begin : g_bad_param
    $error("scan_mux_pipe: N must be a multiple of 4 in 4..64, DWELL in 1..255");
  end

  logic [S-1:0] esel;

  // ---------------- scan sequencer ----------------
`ifdef SCAN_MUX_AUTOSCAN_EN
  state_e       state_q;
  logic [S-1:0] scan_idx_q;
  logic [7:0]   dwell_q;
  logic         wrap_q;
  logic         scan_act;

  // The entry cycle still uses sel; scan_idx is only trusted once loaded.
  assign scan_act = (mode == MODE_SCAN) && (state_q == ST_SCAN);
  assign esel     = scan_act ? scan_idx_q : sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_MANUAL;
      scan_idx_q <= '0;
      dwell_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        ST_MANUAL: begin
          if (mode == MODE_SCAN) begin
            state_q    <= ST_SCAN;
            scan_idx_q <= sel;
            dwell_q    <= '0;
          end
        end
        ST_SCAN: begin
          if (mode != MODE_SCAN) begin
            state_q <= ST_MANUAL;
          end else if (in_valid) begin
            if (dwell_q == 8'(DWELL - 1)) begin
              dwell_q    <= '0;
              scan_idx_q <= (scan_idx_q == S'(N - 1)) ? '0 : scan_idx_q + 1'b1;
              wrap_q     <= (scan_idx_q == S'(N - 1));
            end else begin
              dwell_q <= dwell_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_MANUAL;
      endcase
    end
  end

  assign scan_wrap = wrap_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign esel        = sel;
  assign scan_wrap   = 1'b0;
`endif

  // ---------------- stage 1: N/4 registered 4:1 muxes ----------------
  logic [G-1:0][3:0][W-1:0] grp_in;
  logic [G-1:0][W-1:0]      grp_q;
  logic [S-1:0]             esel_q;
  logic                     vld_q;

  assign grp_in = in_data;

  for (genvar g = 0; g < G; g++) begin : g_grp
    mux4_reg #(.W(W)) u_mux4 (
      .clk   (clk),
      .rst   (rst),
      .d_i   (grp_in[g]),
      .sel_i (esel[1:0]),
      .q_o   (grp_q[g])
    );
  end

  // The full select travels with the data so out_sel matches out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esel_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      esel_q <= esel;
      vld_q  <= in_valid;
    end
  end

  // ---------------- stage 2: (N/4):1 mux ----------------
  logic [S-1:0] gidx;
  logic [W-1:0] out_data_d, out_data_q;
  logic [S-1:0] out_sel_q;
  logic         out_valid_q;

  assign gidx = esel_q >> 2;

  // Compare-based select keeps out-of-range group indices at 0.
  always_comb begin
    out_data_d = '0;
    for (int g = 0; g < G; g++)
      if (gidx == S'(g)) out_data_d = grp_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= esel_q;
      out_valid_q <= vld_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
